// File: rtl/piso_serializer_if.sv
// Word-in / bit-out link bundle for piso_serializer.
// A word moves from master to serializer on a rising edge where in_valid && in_ready
// (and the serializer's en is high); the master holds d and in_valid stable until then.
interface piso_serializer_if #(
  parameter int N = 8
);
  logic [N-1:0] d;
  logic         in_valid;
  logic         in_ready;
  logic         sout;
  logic         sout_valid;
  logic         last;

  modport master (
    output d,
    output in_valid,
    input  in_ready,
    input  sout,
    input  sout_valid,
    input  last
  );

  modport slave (
    input  d,
    input  in_valid,
    output in_ready,
    output sout,
    output sout_valid,
    output last
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out transmitter: loads an N-bit word on a handshake and
// emits it one bit per enabled clock, MSB or LSB first, with back-to-back streaming.
module piso_serializer #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  piso_serializer_if.slave     s,
  output logic                 busy,
  output logic                 dbg_state,
  output logic [$clog2(N)-1:0] dbg_cnt
);

  localparam int CW = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state;
  logic [N-1:0]  sh;
  logic [CW-1:0] cnt;

  logic last_bit;
  logic ready;
  logic accept;

  // All outputs are decoded from registers; only in_ready feeds back into accept.
  assign last_bit = (state == SHIFT) && (cnt == '0);
  assign ready    = (state == IDLE) || last_bit;
  assign accept   = en && s.in_valid && ready;

  assign s.in_ready   = ready;
  assign s.sout_valid = (state == SHIFT);
  assign s.last       = last_bit;
  assign s.sout       = MSB_FIRST ? sh[N-1] : sh[0];
  assign busy         = (state == SHIFT);
  assign dbg_state    = (state == SHIFT);
  assign dbg_cnt      = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
    end else if (en) begin
      if (accept) begin
        // Covers both a load from IDLE and the gap-free reload on the last bit.
        sh    <= s.d;
        cnt   <= CW'(N - 1);
        state <= SHIFT;
      end else if (state == SHIFT) begin
        if (cnt == '0) begin
          // Clearing sh keeps sout at 0 while idle.
          state <= IDLE;
          sh    <= '0;
        end else begin
          if (MSB_FIRST) begin
            sh <= {sh[N-2:0], 1'b0};
          end else begin
            sh <= {1'b0, sh[N-1:1]};
          end
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance
// sharing clk/reset/en, each scenario checking sout/sout_valid/last/busy/in_ready.
module tb_piso_serializer;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       busy_m, busy_l;
  logic       st_m, st_l;
  logic [2:0] cnt_m, cnt_l;

  int errors = 0;
  int checks = 0;

  piso_serializer_if #(.N(N)) m_if ();
  piso_serializer_if #(.N(N)) l_if ();

  piso_serializer #(.N(N), .MSB_FIRST(1'b1)) dut_m (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .s         (m_if),
    .busy      (busy_m),
    .dbg_state (st_m),
    .dbg_cnt   (cnt_m)
  );

  piso_serializer #(.N(N), .MSB_FIRST(1'b0)) dut_l (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .s         (l_if),
    .busy      (busy_l),
    .dbg_state (st_l),
    .dbg_cnt   (cnt_l)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs reflect the new state.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {sout, sout_valid, last, busy, in_ready}
  function automatic logic [4:0] obs_m();
    return {m_if.sout, m_if.sout_valid, m_if.last, busy_m, m_if.in_ready};
  endfunction

  function automatic logic [4:0] obs_l();
    return {l_if.sout, l_if.sout_valid, l_if.last, busy_l, l_if.in_ready};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b0;
    m_if.in_valid = 1'b0;
    m_if.d        = '0;
    l_if.in_valid = 1'b0;
    l_if.d        = '0;
    step();
    step();
    reset = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_m() !== 5'b00001) begin
        errors++;
        $display("FAIL reset_idle_msb cyc%0d: got %b required 00001", i, obs_m());
      end
      checks++;
      if (obs_l() !== 5'b00001) begin
        errors++;
        $display("FAIL reset_idle_lsb cyc%0d: got %b required 00001", i, obs_l());
      end
      step();
    end
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    logic [4:0] req;
    w = 8'b0000_1111;
    m_if.d        = w;
    m_if.in_valid = 1'b1;
    step();
    m_if.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req = {w[7-i], 1'b1, (i == 7), 1'b1, (i == 7)};
      checks++;
      if (obs_m() !== req) begin
        errors++;
        $display("FAIL single bit%0d: got %b required %b", i, obs_m(), req);
      end
      step();
    end
    checks++;
    if (obs_m() !== 5'b00001) begin
      errors++;
      $display("FAIL single_idle: got %b required 00001", obs_m());
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq;
    logic [4:0]  req;
    seq = 16'h0F33;
    m_if.d        = 8'h0F;
    m_if.in_valid = 1'b1;
    step();
    // Next word is held on d from here; ignored until the last-bit edge.
    m_if.d = 8'h33;
    for (int i = 0; i < 16; i++) begin
      req = {seq[15-i], 1'b1, (i == 7 || i == 15), 1'b1, (i == 7 || i == 15)};
      checks++;
      if (obs_m() !== req) begin
        errors++;
        $display("FAIL b2b bit%0d: got %b required %b", i, obs_m(), req);
      end
      if (i >= 8) m_if.in_valid = 1'b0;
      step();
    end
    checks++;
    if (obs_m() !== 5'b00001) begin
      errors++;
      $display("FAIL b2b_idle: got %b required 00001", obs_m());
    end
  endtask

  task automatic test_enable_gating();
    logic [7:0] w;
    logic [4:0] req;
    w = 8'h33;
    m_if.d        = w;
    m_if.in_valid = 1'b1;
    step();
    m_if.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req = {w[7-i], 1'b1, 1'b0, 1'b1, 1'b0};
      checks++;
      if (obs_m() !== req) begin
        errors++;
        $display("FAIL gate_pre bit%0d: got %b required %b", i, obs_m(), req);
      end
      step();
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({obs_m(), cnt_m} !== {5'b11010, 3'd4}) begin
        errors++;
        $display("FAIL gate_frozen cyc%0d: got %b/%0d required 11010/4", i, obs_m(), cnt_m);
      end
      step();
    end
    en = 1'b1;
    for (int i = 3; i < 8; i++) begin
      req = {w[7-i], 1'b1, (i == 7), 1'b1, (i == 7)};
      checks++;
      if (obs_m() !== req) begin
        errors++;
        $display("FAIL gate_post bit%0d: got %b required %b", i, obs_m(), req);
      end
      step();
    end
    checks++;
    if (obs_m() !== 5'b00001) begin
      errors++;
      $display("FAIL gate_idle: got %b required 00001", obs_m());
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    logic [4:0] req;
    m_if.d        = 8'hF0;
    m_if.in_valid = 1'b1;
    step();
    m_if.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_m() !== 5'b11010) begin
        errors++;
        $display("FAIL rstmid_pre bit%0d: got %b required 11010", i, obs_m());
      end
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (obs_m() !== 5'b00001) begin
      errors++;
      $display("FAIL rstmid_abort: got %b required 00001", obs_m());
    end
    w = 8'hAA;
    m_if.d        = w;
    m_if.in_valid = 1'b1;
    step();
    m_if.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req = {w[7-i], 1'b1, (i == 7), 1'b1, (i == 7)};
      checks++;
      if (obs_m() !== req) begin
        errors++;
        $display("FAIL rstmid_new bit%0d: got %b required %b", i, obs_m(), req);
      end
      step();
    end
  endtask

  task automatic test_reset_and_accept();
    m_if.d        = 8'hAA;
    m_if.in_valid = 1'b1;
    reset         = 1'b1;
    step();
    reset         = 1'b0;
    m_if.in_valid = 1'b0;
    checks++;
    if (obs_m() !== 5'b00001) begin
      errors++;
      $display("FAIL reset_wins: got %b required 00001", obs_m());
    end
    step();
    checks++;
    if (obs_m() !== 5'b00001) begin
      errors++;
      $display("FAIL reset_wins_after: got %b required 00001", obs_m());
    end
  endtask

  task automatic test_en_blocks_accept();
    en            = 1'b0;
    m_if.d        = 8'h81;
    m_if.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (obs_m() !== 5'b00001) begin
        errors++;
        $display("FAIL en_low_no_accept cyc%0d: got %b required 00001", i, obs_m());
      end
    end
    en = 1'b1;
    step();
    m_if.in_valid = 1'b0;
    checks++;
    if (obs_m() !== 5'b11010) begin
      errors++;
      $display("FAIL en_high_accept: got %b required 11010", obs_m());
    end
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (obs_m() !== 5'b00001) begin
      errors++;
      $display("FAIL en_drain_idle: got %b required 00001", obs_m());
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    logic [4:0] req;
    w = 8'b0111_0000;
    l_if.d        = w;
    l_if.in_valid = 1'b1;
    step();
    l_if.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req = {w[i], 1'b1, (i == 7), 1'b1, (i == 7)};
      checks++;
      if (obs_l() !== req) begin
        errors++;
        $display("FAIL lsb bit%0d: got %b required %b", i, obs_l(), req);
      end
      step();
    end
    checks++;
    if (obs_l() !== 5'b00001) begin
      errors++;
      $display("FAIL lsb_idle: got %b required 00001", obs_l());
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_enable_gating();
    test_reset_mid_word();
    test_reset_and_accept();
    test_en_blocks_accept();
    test_lsb_first();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
